// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and defaults for the ALU operation sequencer
//
// Purpose: operation codes, sequencer state encoding, default widths and timeout,
//          plus a helper that tells whether an op needs an external arithmetic unit.
// Ports:   none (package)
package alu_pkg;

    localparam int ALU_W       = 3;
    localparam int ALU_RW      = 2 * ALU_W;
    localparam int ALU_TIMEOUT = 31;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_e;

    // mul and div are handed to the multi-cycle units; add and sub are done locally
    function automatic logic is_unit_op(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_timer.sv
// rtl/alu_seq_timer.sv - WAIT-cycle counter with clear/enable and expiry flag
//
// Purpose: counts the cycles the sequencer spends waiting on an arithmetic unit.
//          expired is high during the TIMEOUT-th waiting cycle, so a unit is given
//          exactly TIMEOUT cycles to answer before the sequencer aborts.
// Ports:   clk, reset (sync, active-low), clr (zero the count), en (count this cycle),
//          expired (current cycle is the last one allowed).
module alu_seq_timer
    import alu_pkg::*;
#(
    parameter int TIMEOUT = ALU_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // count_q holds the number of waiting cycles already elapsed before this one
    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - front-end controller launching add/sub/mul/div operations
//
// Purpose: accepts one request, computes add/sub locally, launches the multiplier or
//          divider with a one-cycle init pulse, waits for its done or a timeout, then
//          presents the latched result with a one-cycle done pulse.
// Macro:   DIV_ZERO_CHECK_EN - when defined, a divide by zero finishes immediately with
//          err=1 and result=0 without launching the divider.
// Ports:   clk, reset (sync, active-low)
//          init, op, a, b          request strobe, opcode, operands
//          busy, done, result, err operation status and latched outcome
//          mul_init, div_init      one-cycle launch pulses to the units
//          unit_a, unit_b          captured operands driven to both units
//          mul_res, mul_done       multiplier answer
//          div_res, div_done       divider answer {remainder, quotient}
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int W       = ALU_W,
    parameter int RW      = ALU_RW,
    parameter int TIMEOUT = ALU_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init,
    input  logic [1:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] result,
    output logic          err,
    output logic          mul_init,
    output logic          div_init,
    output logic [W-1:0]  unit_a,
    output logic [W-1:0]  unit_b,
    input  logic [RW-1:0] mul_res,
    input  logic          mul_done,
    input  logic [RW-1:0] div_res,
    input  logic          div_done
);

    seq_state_e    state_q, state_d;
    alu_op_e       op_q, op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RW-1:0] result_q, result_d;
    logic          err_q, err_d;
    logic          mul_init_q, mul_init_d;
    logic          div_init_q, div_init_d;
    logic [W-1:0]  unit_a_q, unit_a_d;
    logic [W-1:0]  unit_b_q, unit_b_d;
    // outcome of a unit operation, held until FINISH publishes it
    logic [RW-1:0] pend_res_q, pend_res_d;
    logic          pend_err_q, pend_err_d;

    alu_op_e       op_req;
    logic          div_zero;
    logic          sel_done;
    logic [RW-1:0] sel_res;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic          timer_clr;
    logic          timer_en;
    logic          timer_expired;

    assign op_req = alu_op_e'(op);
    assign a_ext  = {{(RW - W){1'b0}}, unit_a_q};
    assign b_ext  = {{(RW - W){1'b0}}, unit_b_q};

    assign sel_done = (op_q == OP_MUL) ? mul_done : div_done;
    assign sel_res  = (op_q == OP_MUL) ? mul_res  : div_res;

    alu_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        done_d     = 1'b0;
        result_d   = result_q;
        err_d      = err_q;
        mul_init_d = 1'b0;
        div_init_d = 1'b0;
        unit_a_d   = unit_a_q;
        unit_b_d   = unit_b_q;
        pend_res_d = pend_res_q;
        pend_err_d = pend_err_q;
        timer_clr  = 1'b0;
        timer_en   = 1'b0;

        div_zero = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
        div_zero = (op_req == OP_DIV) && (b == '0);
`endif

        case (state_q)
            ST_IDLE: begin
                // the done cycle still belongs to the completing operation, so a
                // request arriving together with done is dropped
                if (init && !done_q) begin
                    op_d       = op_req;
                    unit_a_d   = a;
                    unit_b_d   = b;
                    pend_res_d = '0;
                    pend_err_d = 1'b0;
                    if (is_unit_op(op_req) && !div_zero) begin
                        state_d    = ST_LAUNCH;
                        mul_init_d = (op_req == OP_MUL);
                        div_init_d = (op_req == OP_DIV);
                    end else begin
                        state_d    = ST_FINISH;
                        pend_err_d = div_zero;
                    end
                end
            end
            ST_LAUNCH: begin
                timer_clr = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // a unit answer in the final allowed cycle wins over the timeout
                if (sel_done) begin
                    pend_res_d = sel_res;
                    state_d    = ST_FINISH;
                end else if (timer_expired) begin
                    pend_res_d = '0;
                    pend_err_d = 1'b1;
                    state_d    = ST_FINISH;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                err_d   = pend_err_q;
                state_d = ST_IDLE;
                case (op_q)
                    OP_ADD:  result_d = a_ext + b_ext;
                    OP_SUB:  result_d = a_ext - b_ext;
                    default: result_d = pend_res_q;
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_ADD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            mul_init_q <= 1'b0;
            div_init_q <= 1'b0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            pend_res_q <= '0;
            pend_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            err_q      <= err_d;
            mul_init_q <= mul_init_d;
            div_init_q <= div_init_d;
            unit_a_q   <= unit_a_d;
            unit_b_q   <= unit_b_d;
            pend_res_q <= pend_res_d;
            pend_err_q <= pend_err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign err      = err_q;
    assign mul_init = mul_init_q;
    assign div_init = div_init_q;
    assign unit_a   = unit_a_q;
    assign unit_b   = unit_b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with unit models
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int W  = 3;
    localparam int RW = 6;
    localparam int T  = 31;

`ifdef DIV_ZERO_CHECK_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, err, mul_init, div_init;
    logic [RW-1:0] result;
    logic [W-1:0]  unit_a, unit_b;
    logic [RW-1:0] mul_res = '0;
    logic [RW-1:0] div_res = '0;
    logic          mul_done = 1'b0;
    logic          div_done = 1'b0;

    alu_op_sequencer #(.W(W), .RW(RW), .TIMEOUT(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err),
        .mul_init (mul_init),
        .div_init (div_init),
        .unit_a   (unit_a),
        .unit_b   (unit_b),
        .mul_res  (mul_res),
        .mul_done (mul_done),
        .div_res  (div_res),
        .div_done (div_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] res;
        logic          err;
        int            due;
        int            n_mul;
        int            n_div;
        int            op_code;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [RW-1:0] div_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        if (y == '0) return '1;
        return {W'(x % y), W'(x / y)};
    endfunction

    // expected outcome from the behavioural rules; lat = unit response delay after its
    // init pulse (0 = never answers)
    function automatic exp_t ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                    input logic [W-1:0] y, input int lat);
        exp_t e;
        e.err = 1'b0; e.n_mul = 0; e.n_div = 0; e.op_code = int'(o); e.due = 2;
        e.res = '0;
        if (o == 2'b00) begin
            e.res = RW'(int'(x) + int'(y));
        end else if (o == 2'b01) begin
            e.res = RW'(int'(x) - int'(y));
        end else if (o == 2'b11 && y == '0 && DZ_EN) begin
            e.err = 1'b1;
        end else begin
            if (o == 2'b10) e.n_mul = 1; else e.n_div = 1;
            if (lat >= 1 && lat <= T) begin
                e.res = (o == 2'b10) ? RW'(int'(x) * int'(y)) : div_ref(x, y);
                e.due = 3 + lat;
            end else begin
                e.err = 1'b1;
                e.due = T + 3;
            end
        end
        return e;
    endfunction

    // arithmetic unit models, with noise on the unit that is not in use
    int            mul_lat = 0, div_lat = 0;
    int            mul_due = -1, div_due = -1;
    logic [RW-1:0] mul_val = '0, div_val = '0;
    logic [1:0]    active_op = 2'b00;

    always @(posedge clk) begin
        #3;
        if (reset !== 1'b1) begin
            mul_due = -1;
            div_due = -1;
        end else begin
            if (mul_init === 1'b1 && mul_lat > 0) begin
                mul_due = cyc + mul_lat;
                mul_val = RW'(int'(unit_a) * int'(unit_b));
            end
            if (div_init === 1'b1 && div_lat > 0) begin
                div_due = cyc + div_lat;
                div_val = div_ref(unit_a, unit_b);
            end
        end
        mul_done = (cyc == mul_due);
        mul_res  = mul_done ? mul_val : RW'($urandom_range(63));
        if (!mul_done && active_op == 2'b11 && $urandom_range(3) == 0) mul_done = 1'b1;
        div_done = (cyc == div_due);
        div_res  = div_done ? div_val : RW'($urandom_range(63));
        if (!div_done && active_op == 2'b10 && $urandom_range(3) == 0) div_done = 1'b1;
    end

    // monitor: pops an expectation whenever done is presented
    int   n_mul_seen = 0, n_div_seen = 0;
    exp_t me;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            n_mul_seen = 0;
            n_div_seen = 0;
        end else begin
            if (mul_init === 1'b1) n_mul_seen++;
            if (div_init === 1'b1) n_div_seen++;
            if (done !== 1'b0) begin
                if (sbq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: done=%b result=%0h at cycle %0d, expected no done",
                             done, result, cyc);
                end else begin
                    me = sbq.pop_front();
                    chk($sformatf("result op%0d", me.op_code), 32'(result), 32'(me.res));
                    chk($sformatf("err op%0d", me.op_code), 32'(err), 32'(me.err));
                    chk($sformatf("done_cycle op%0d", me.op_code), cyc, me.due);
                    chk("busy_at_done", 32'(busy), 0);
                    chk("mul_init_pulses", n_mul_seen, me.n_mul);
                    chk("div_init_pulses", n_div_seen, me.n_div);
                    n_mul_seen = 0;
                    n_div_seen = 0;
                end
            end
        end
    end

    // call at posedge+1; returns at posedge+1 of the cycle after the expected done
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int lat, input bit junk_at_done);
        exp_t e;
        int   rel;
        e   = ref_op(o, x, y, lat);
        rel = e.due;
        mul_lat   = lat;
        div_lat   = lat;
        active_op = o;
        init = 1'b1; op = o; a = x; b = y;
        e.due = cyc + rel;
        sbq.push_back(e);
        for (int k = 1; k <= rel; k++) begin
            @(posedge clk); #1;
            if (k == rel) init = junk_at_done ? 1'b1 : 1'($urandom_range(1));
            else          init = ($urandom_range(3) == 0);
            op = 2'($urandom_range(3));
            a  = W'($urandom_range(7));
            b  = W'($urandom_range(7));
            if (k == 1) begin
                #3;
                chk("busy_after_accept", 32'(busy), 1);
            end
        end
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    initial begin
        int lat, r;
        reset = 1'b0; init = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mul_init", 32'(mul_init), 0);
        chk("rst_div_init", 32'(div_init), 0);
        chk("rst_unit_a", 32'(unit_a), 0);
        chk("rst_unit_b", 32'(unit_b), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        issue(2'b00, 3'd7, 3'd7, 0, 1'b1);
        issue(2'b01, 3'd2, 3'd5, 0, 1'b1);

        // reset in the middle of a divide wait: no done, outputs cleared
        active_op = 2'b11; div_lat = 0; mul_lat = 0;
        init = 1'b1; op = 2'b11; a = 3'd5; b = 3'd3;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_div_init", 32'(div_init), 0);
        chk("midrst_mul_init", 32'(mul_init), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_idle_busy", 32'(busy), 0);

        issue(2'b11, 3'd6, 3'd4, 9, 1'b1);
        issue(2'b10, 3'd5, 3'd3, 0, 1'b1);
        issue(2'b11, 3'd5, 3'd0, 4, 1'b1);
        issue(2'b10, 3'd7, 3'd7, T, 1'b0);
        issue(2'b10, 3'd6, 3'd3, T + 1, 1'b0);

        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(9);
            case (r)
                0:       lat = 0;
                1:       lat = T + 1;
                2:       lat = T;
                3:       lat = 1;
                default: lat = $urandom_range(12, 1);
            endcase
            issue(2'($urandom_range(3)), W'($urandom_range(7)), W'($urandom_range(7)),
                  lat, 1'($urandom_range(1)));
            repeat ($urandom_range(2)) @(posedge clk);
            #1;
        end

        for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected responses never arrived, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
